// File: rtl/iob_wishbone_pkg.sv
// Shared definitions for the Wishbone-to-IOb register bridge: FSM encoding
// and default timeout counter sizing.
package iob_wishbone_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int TIMEOUT_DEF   = 0;
  localparam int TIMEOUT_W_DEF = 16;

endpackage

// File: rtl/iob_timeout_cnt.sv
// Request timeout counter: cleared between transactions, counts enabled cycles,
// flags the cycle whose increment reaches TIMEOUT (never fires when TIMEOUT is 0).
module iob_timeout_cnt #(
  parameter int TIMEOUT   = 0,
  parameter int TIMEOUT_W = 16
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires combinationally so the FSM can leave on the very cycle the limit is hit.
  assign done_o = (TIMEOUT != 0) && en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/iob_wishbone2iob_reg.sv
// Wishbone slave to IOb master bridge with registered request/response paths,
// optional request timeout and master-abort draining.
module iob_wishbone2iob_reg
  import iob_wishbone_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                valid_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                ready_i,
  input  logic                err_i
);

  state_t              state_q;
  logic                valid_q;
  logic                ack_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdat_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  logic cnt_clr, cnt_en, cnt_done;

  assign cnt_clr = (state_q == IDLE);
  assign cnt_en  = ((state_q == REQ) || (state_q == DRAIN)) && !ready_i;

  iob_timeout_cnt #(
    .TIMEOUT  (TIMEOUT),
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timeout (
    .clk_i (clk_i),
    .arst_i(arst_i),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .done_o(cnt_done)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            addr_q  <= wb_adr_i;
            wdata_q <= wb_dat_i;
            wstrb_q <= wb_we_i ? wb_sel_i : '0;
            valid_q <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            if (wb_cyc_i) begin
              rdat_q  <= rdata_i;
              ack_q   <= !err_i;
              err_q   <= err_i;
              state_q <= RESP;
            end else begin
              // Abort coinciding with the response: nothing left to drain.
              state_q <= IDLE;
            end
          end else if (!wb_cyc_i) begin
            valid_q <= 1'b0;
            state_q <= cnt_done ? IDLE : DRAIN;
          end else if (cnt_done) begin
            valid_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        DRAIN: begin
          if (ready_i || cnt_done) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = rdat_q;
  assign valid_o  = valid_q;
  assign addr_o   = addr_q;
  assign wdata_o  = wdata_q;
  assign wstrb_o  = wstrb_q;

endmodule

// File: doc/iob_wishbone2iob_reg.md
IOB_WISHBONE2IOB_REG -- requirements
Module: iob_wishbone2iob_reg

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width; multiple of 8.
REQ-003 Parameter TIMEOUT, default 0, cycles to wait for ready_i; 0 disables the timeout.
REQ-004 Parameter TIMEOUT_W, default 16, timeout counter width; TIMEOUT < 2**TIMEOUT_W.
REQ-005 clk_i  input  1  single clock; all state on rising edge.
REQ-006 arst_i  input  1  reset, asynchronous, active-high.
REQ-007 wb_adr_i  input  ADDR_W  Wishbone address.
REQ-008 wb_sel_i  input  DATA_W/8  byte selects.
REQ-009 wb_we_i, wb_cyc_i, wb_stb_i  input  1 each  write enable, cycle, strobe.
REQ-010 wb_dat_i  input  DATA_W  write data.
REQ-011 wb_ack_o, wb_err_o  output  1 each  normal / error termination.
REQ-012 wb_dat_o  output  DATA_W  registered read data.
REQ-013 valid_o  output  1  IOb request valid.
REQ-014 addr_o  output  ADDR_W  registered IOb address.
REQ-015 wdata_o  output  DATA_W  registered IOb write data.
REQ-016 wstrb_o  output  DATA_W/8  byte strobes; all zero on reads.
REQ-017 rdata_i, ready_i, err_i  input  DATA_W, 1, 1  IOb response; ready_i is a one-cycle pulse, rdata_i/err_i valid with it.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, RESP, DRAIN.
REQ-019 In IDLE with wb_cyc_i&wb_stb_i=1, the block SHALL register addr, wdata, and wstrb (wb_sel_i if wb_we_i, else 0), clear the timeout counter, and go to REQ.
REQ-020 In REQ, valid_o SHALL be 1; in every other state valid_o SHALL be 0.
REQ-021 addr_o/wdata_o/wstrb_o SHALL hold the registered values from capture until the next capture.
REQ-022 In REQ with ready_i=1, the block SHALL capture rdata_i into wb_dat_o and err_i into an error flag, then go to RESP.
REQ-023 In RESP, exactly one of wb_ack_o (flag=0) or wb_err_o (flag=1) SHALL be 1 for one cycle, then go to IDLE.
REQ-024 Latency: strobe seen in cycle 0 -> valid_o in cycle 1 -> ready_i in cycle k>=1 -> termination in cycle k+1.
REQ-025 With TIMEOUT>0, the counter SHALL increment each REQ cycle without ready_i; on reaching TIMEOUT the block SHALL set the error flag and go to RESP (wb_err_o pulse).
REQ-026 ready_i in the same cycle the counter reaches TIMEOUT SHALL take priority: the response is captured normally.
REQ-027 In REQ with wb_cyc_i=0 (master abort), the block SHALL go to DRAIN, keeping valid_o=0.
REQ-028 In DRAIN, the block SHALL wait for ready_i (or timeout), discard the response without terminating Wishbone, and return to IDLE.
REQ-029 ready_i received in IDLE, RESP, or DRAIN-completed states SHALL be ignored.
REQ-030 Never more than one IOb transaction SHALL be outstanding; new strobes are accepted only in IDLE.
REQ-031 wb_ack_o and wb_err_o SHALL never both be 1.

Reset
REQ-032 arst_i=1 SHALL immediately force the FSM to IDLE and all outputs and registers to 0, including mid-transaction.
REQ-033 After reset, the first accepted strobe SHALL be the first cycle that has cyc&stb high following arst_i deassertion.

Structure
REQ-034 The FSM state encoding and the TIMEOUT counter-width localparams SHALL reside in the shared iob_wishbone_pkg.
REQ-035 The timeout counter SHALL be one sub-module, iob_timeout_cnt (clear, enable, done).

Verification
REQ-036 Write: adr=0x10, dat=0xDEADBEEF, sel=0xF, we=1; ready_i 3 cycles after valid_o -> wstrb_o=0xF, one wb_ack_o pulse 1 cycle after ready_i.
REQ-037 Read: adr=0x20, we=0; rdata_i=0x12345678 with ready_i -> wstrb_o=0, wb_dat_o=0x12345678 with wb_ack_o.
REQ-038 Timeout: TIMEOUT=8, ready_i never arrives -> valid_o high 8 cycles, then one wb_err_o pulse, no wb_ack_o.
REQ-039 Error response: ready_i with err_i=1 -> wb_err_o pulse, wb_ack_o stays 0.
REQ-040 Abort: wb_cyc_i dropped 2 cycles into REQ, ready_i 4 cycles later -> no ack/err; the next strobe is served normally.
REQ-041 Reset mid-REQ: arst_i pulsed -> valid_o=0 the same cycle, FSM IDLE, late ready_i ignored.
